// File: rtl/jtag_bsr_pkg.sv
// Shared types and helpers for the JTAG boundary-scan register family.
package jtag_bsr_pkg;

    typedef enum logic [1:0] {
        BSR_IDLE,
        BSR_CAPTURED,
        BSR_SHIFTING,
        BSR_UPDATED
    } bsr_state_e;

    // Bits needed to count 0..width inclusive.
    function automatic int bsr_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/jtag_bypass_reg.sv
// Single-bit JTAG bypass register; capture clears it, shift loads tdi.
module jtag_bypass_reg (
    input  logic tck,
    input  logic rst,
    input  logic capture_en,
    input  logic shift_en,
    input  logic tdi,
    output logic bp
);

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            bp <= 1'b0;
        end else if (capture_en) begin
            bp <= 1'b0;
        end else if (shift_en) begin
            bp <= tdi;
        end
    end

endmodule

// File: rtl/boundary_scan_register_n.sv
// WIDTH-bit boundary-scan register with capture/shift/update, bypass path,
// saturating shift counter, coarse state and a sticky short-update flag.
module boundary_scan_register_n
    import jtag_bsr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          tck,
    input  logic                          rst,
    input  logic                          tdi,
    output logic                          tdo,
    input  logic                          capture_en,
    input  logic                          shift_en,
    input  logic                          update_en,
    input  logic                          bypass,
    input  logic                          extest,
    input  logic [WIDTH-1:0]              data_in,
    output logic [WIDTH-1:0]              data_out,
    output logic [bsr_cnt_w(WIDTH)-1:0]   shift_count,
    output logic                          shift_full,
    output logic                          short_update,
    output bsr_state_e                    state
);

    localparam int            CW   = bsr_cnt_w(WIDTH);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] ur;
    logic             bp;

    jtag_bypass_reg u_bypass (
        .tck        (tck),
        .rst        (rst),
        .capture_en (capture_en & bypass),
        .shift_en   (shift_en & bypass),
        .tdi        (tdi),
        .bp         (bp)
    );

    // Everything here freezes while bypassed so sr survives bypass intervals;
    // update and the short flag look at the pre-edge sr/count.
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            sr           <= '0;
            ur           <= RESET_VALUE;
            shift_count  <= '0;
            short_update <= 1'b0;
            state        <= BSR_IDLE;
        end else if (!bypass) begin
            if (capture_en) begin
                sr          <= data_in;
                shift_count <= '0;
            end else if (shift_en) begin
                sr <= {tdi, sr[WIDTH-1:1]};
                if (shift_count != FULL) begin
                    shift_count <= shift_count + CW'(1);
                end
            end

            if (update_en) begin
                ur <= sr;
            end

            if (capture_en) begin
                short_update <= 1'b0;
            end else if (update_en && (shift_count != FULL)) begin
                short_update <= 1'b1;
            end

            if (capture_en) begin
                state <= BSR_CAPTURED;
            end else if (shift_en) begin
                state <= BSR_SHIFTING;
            end else if (update_en) begin
                state <= BSR_UPDATED;
            end
        end
    end

    assign shift_full = (shift_count == FULL);
    assign tdo        = bypass ? bp : sr[0];
    assign data_out   = extest ? ur : data_in;

endmodule

// File: tb/tb_boundary_scan_register_n.sv
// Self-checking bench for boundary_scan_register_n at WIDTH=8 and WIDTH=16,
// comparing against a queue-based scan-chain model.
module tb_boundary_scan_register_n;
    import jtag_bsr_pkg::*;

    int checks   = 0;
    int failures = 0;

    logic        tck = 1'b0;
    logic        rst = 1'b1;
    logic        tdi = 1'b0;
    logic        cap = 1'b0;
    logic        sh  = 1'b0;
    logic        upd = 1'b0;
    logic        byp = 1'b0;
    logic        ext = 1'b0;
    logic [15:0] din = '0;
    logic        sel16 = 1'b0;

    logic        tdo8, tdo16;
    logic [7:0]  dout8;
    logic [15:0] dout16;
    logic [3:0]  cnt8;
    logic [4:0]  cnt16;
    logic        full8, full16, short8, short16;
    bsr_state_e  st8, st16;

    logic        obs_tdo;
    logic [15:0] obs_dout;
    int          obs_count;
    logic        obs_full;
    logic        obs_short;
    logic [1:0]  obs_state;

    always #5 tck = ~tck;

    boundary_scan_register_n #(.WIDTH(8), .RESET_VALUE(8'h00)) dut8 (
        .tck(tck), .rst(rst), .tdi(tdi), .tdo(tdo8),
        .capture_en(cap & ~sel16), .shift_en(sh & ~sel16), .update_en(upd & ~sel16),
        .bypass(byp), .extest(ext), .data_in(din[7:0]), .data_out(dout8),
        .shift_count(cnt8), .shift_full(full8), .short_update(short8), .state(st8)
    );

    boundary_scan_register_n #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut16 (
        .tck(tck), .rst(rst), .tdi(tdi), .tdo(tdo16),
        .capture_en(cap & sel16), .shift_en(sh & sel16), .update_en(upd & sel16),
        .bypass(byp), .extest(ext), .data_in(din), .data_out(dout16),
        .shift_count(cnt16), .shift_full(full16), .short_update(short16), .state(st16)
    );

    always_comb begin
        obs_tdo   = sel16 ? tdo16   : tdo8;
        obs_dout  = sel16 ? dout16  : {8'h00, dout8};
        obs_count = sel16 ? int'(cnt16) : int'(cnt8);
        obs_full  = sel16 ? full16  : full8;
        obs_short = sel16 ? short16 : short8;
        obs_state = sel16 ? st16    : st8;
    end

    // Reference model: the scan chain is a queue whose front is the bit at tdo.
    int          W = 8;
    bit          mq[$];
    logic [15:0] m_ur;
    int          m_count;
    bit          m_short;
    bit          m_bp;
    logic [1:0]  m_state;

    function automatic logic [15:0] mask_w();
        return (W == 16) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [15:0] q_vec();
        logic [15:0] v = '0;
        for (int i = 0; i < mq.size(); i++) v[i] = mq[i];
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < W; i++) mq.push_back(1'b0);
        m_ur    = '0;
        m_count = 0;
        m_short = 1'b0;
        m_bp    = 1'b0;
        m_state = BSR_IDLE;
    endtask

    task automatic model_edge(input bit c, input bit s, input bit u, input bit t,
                              input logic [15:0] d);
        logic [15:0] pre;
        int          pre_cnt;
        if (byp) begin
            if (c) m_bp = 1'b0;
            else if (s) m_bp = t;
            return;
        end
        pre     = q_vec();
        pre_cnt = m_count;
        if (c) begin
            mq.delete();
            for (int i = 0; i < W; i++) mq.push_back(d[i]);
            m_count = 0;
        end else if (s) begin
            void'(mq.pop_front());
            mq.push_back(t);
            if (m_count < W) m_count++;
        end
        if (u) begin
            m_ur = pre;
            if (pre_cnt != W) m_short = 1'b1;
        end
        if (c) m_short = 1'b0;
        if (c)      m_state = BSR_CAPTURED;
        else if (s) m_state = BSR_SHIFTING;
        else if (u) m_state = BSR_UPDATED;
    endtask

    // One scan clock: drive strobes on the falling edge, sample 1 after rising.
    task automatic cycle(input bit c, input bit s, input bit u, input bit t,
                         input logic [15:0] d);
        @(negedge tck);
        cap = c; sh = s; upd = u; tdi = t; din = d & mask_w();
        model_edge(c, s, u, t, d & mask_w());
        @(posedge tck);
        #1;
        cap = 1'b0; sh = 1'b0; upd = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge tck);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic select_width(input bit s16);
        sel16 = s16;
        W     = s16 ? 16 : 8;
        byp   = 1'b0;
        do_reset();
    endtask

    // Asynchronous reset in the middle of the 4th shift.
    task automatic test_reset();
        select_width(1'b0);
        ext = 1'b1;
        cycle(1, 0, 0, 0, 16'hFF);
        cycle(0, 0, 1, 0, 16'hFF);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, 16'hFF);
        @(negedge tck);
        sh = 1'b1; tdi = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (obs_tdo !== 1'b0) begin failures++; $display("[TB] FAIL reset_tdo got=%0b exp=0", obs_tdo); end
        checks++; if (obs_dout !== 16'h0000) begin failures++; $display("[TB] FAIL reset_dout got=%h exp=00", obs_dout); end
        checks++; if (obs_count !== 0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", obs_count); end
        checks++; if (obs_state !== BSR_IDLE) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=0", obs_state); end
        checks++; if (obs_short !== 1'b0) begin failures++; $display("[TB] FAIL reset_short got=%0b exp=0", obs_short); end
        checks++; if (obs_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%0b exp=0", obs_full); end
        @(posedge tck);
        #1;
        @(negedge tck);
        rst = 1'b0; sh = 1'b0;
        model_reset();
    endtask

    task automatic test_capture_shift_update(input bit s16, input logic [15:0] cv,
                                             input logic [15:0] tv);
        select_width(s16);
        ext = 1'b1;
        cycle(1, 0, 0, 0, cv);
        checks++; if (obs_tdo !== cv[0]) begin failures++; $display("[TB] FAIL csu_tdo0 w=%0d got=%0b exp=%0b", W, obs_tdo, cv[0]); end
        for (int i = 0; i < W; i++) begin
            cycle(0, 1, 0, tv[i], cv);
            if (i < W - 1) begin
                checks++;
                if (obs_tdo !== cv[i+1]) begin failures++; $display("[TB] FAIL csu_tdo w=%0d shift=%0d got=%0b exp=%0b", W, i + 1, obs_tdo, cv[i+1]); end
            end
        end
        checks++; if (obs_full !== 1'b1) begin failures++; $display("[TB] FAIL csu_full w=%0d got=%0b exp=1", W, obs_full); end
        checks++; if (obs_count !== W) begin failures++; $display("[TB] FAIL csu_count w=%0d got=%0d exp=%0d", W, obs_count, W); end
        cycle(0, 0, 1, 0, cv);
        checks++; if (obs_dout !== (tv & mask_w())) begin failures++; $display("[TB] FAIL csu_dout w=%0d got=%h exp=%h", W, obs_dout, tv & mask_w()); end
        checks++; if (obs_short !== 1'b0) begin failures++; $display("[TB] FAIL csu_short w=%0d got=%0b exp=0", W, obs_short); end
        checks++; if (obs_state !== BSR_UPDATED) begin failures++; $display("[TB] FAIL csu_state w=%0d got=%0d exp=3", W, obs_state); end
    endtask

    task automatic test_short_update(input bit s16);
        logic [15:0] exp_dout;
        select_width(s16);
        ext = 1'b1;
        cycle(1, 0, 0, 0, mask_w());
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, mask_w());
        cycle(0, 0, 1, 0, mask_w());
        exp_dout = mask_w() >> 5;
        checks++; if (obs_short !== 1'b1) begin failures++; $display("[TB] FAIL short_set w=%0d got=%0b exp=1", W, obs_short); end
        checks++; if (obs_dout !== exp_dout) begin failures++; $display("[TB] FAIL short_dout w=%0d got=%h exp=%h", W, obs_dout, exp_dout); end
        cycle(1, 0, 0, 0, 16'h0000);
        checks++; if (obs_short !== 1'b0) begin failures++; $display("[TB] FAIL short_clear w=%0d got=%0b exp=0", W, obs_short); end
        for (int i = 0; i < W + 2; i++) cycle(0, 1, 0, 1, 16'h0000);
        checks++; if (obs_count !== W) begin failures++; $display("[TB] FAIL sat_count w=%0d got=%0d exp=%0d", W, obs_count, W); end
        checks++; if (obs_full !== 1'b1) begin failures++; $display("[TB] FAIL sat_full w=%0d got=%0b exp=1", W, obs_full); end
    endtask

    task automatic test_bypass();
        logic [15:0] keep_ur;
        int          keep_cnt;
        logic [1:0]  keep_state;
        bit          keep_sr0;
        bit          seq[3] = '{1'b1, 1'b1, 1'b0};
        select_width(1'b0);
        ext = 1'b1;
        cycle(1, 0, 0, 0, 16'h96);
        cycle(0, 1, 0, 1, 16'h96);
        cycle(0, 1, 1, 1, 16'h96);
        keep_ur = m_ur; keep_cnt = m_count; keep_state = m_state; keep_sr0 = mq[0];
        byp = 1'b1;
        cycle(1, 0, 0, 0, 16'h00);
        checks++; if (obs_tdo !== 1'b0) begin failures++; $display("[TB] FAIL byp_cap_tdo got=%0b exp=0", obs_tdo); end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, seq[i], 16'h00);
            checks++; if (obs_tdo !== seq[i]) begin failures++; $display("[TB] FAIL byp_tdo step=%0d got=%0b exp=%0b", i, obs_tdo, seq[i]); end
        end
        cycle(0, 0, 1, 0, 16'h00);
        checks++; if (obs_dout !== keep_ur) begin failures++; $display("[TB] FAIL byp_dout got=%h exp=%h", obs_dout, keep_ur); end
        checks++; if (obs_count !== keep_cnt) begin failures++; $display("[TB] FAIL byp_count got=%0d exp=%0d", obs_count, keep_cnt); end
        checks++; if (obs_state !== keep_state) begin failures++; $display("[TB] FAIL byp_state got=%0d exp=%0d", obs_state, keep_state); end
        byp = 1'b0;
        #1;
        checks++; if (obs_tdo !== keep_sr0) begin failures++; $display("[TB] FAIL byp_sr_kept got=%0b exp=%0b", obs_tdo, keep_sr0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_sr = 8'hAD;
        select_width(1'b0);
        ext = 1'b1;
        cycle(1, 0, 0, 0, 16'h5A);
        cycle(0, 1, 1, 1, 16'h5A);
        checks++; if (obs_dout !== 16'h005A) begin failures++; $display("[TB] FAIL b2b_ur got=%h exp=5a", obs_dout); end
        checks++; if (obs_state !== BSR_SHIFTING) begin failures++; $display("[TB] FAIL b2b_state got=%0d exp=2", obs_state); end
        checks++; if (obs_tdo !== exp_sr[0]) begin failures++; $display("[TB] FAIL b2b_sr bit=0 got=%0b exp=%0b", obs_tdo, exp_sr[0]); end
        for (int i = 1; i < 8; i++) begin
            cycle(0, 1, 0, 0, 16'h5A);
            checks++; if (obs_tdo !== exp_sr[i]) begin failures++; $display("[TB] FAIL b2b_sr bit=%0d got=%0b exp=%0b", i, obs_tdo, exp_sr[i]); end
        end
    endtask

    task automatic test_extest_passthrough();
        select_width(1'b0);
        ext = 1'b1;
        cycle(1, 0, 0, 0, 16'h3C);
        cycle(0, 0, 1, 0, 16'h3C);
        ext = 1'b0;
        din = 16'h0011;
        #1;
        checks++; if (obs_dout !== 16'h0011) begin failures++; $display("[TB] FAIL pass_11 got=%h exp=11", obs_dout); end
        din = 16'h00EE;
        #1;
        checks++; if (obs_dout !== 16'h00EE) begin failures++; $display("[TB] FAIL pass_ee got=%h exp=ee", obs_dout); end
        ext = 1'b1;
        #1;
        checks++; if (obs_dout !== 16'h003C) begin failures++; $display("[TB] FAIL pass_restore got=%h exp=3c", obs_dout); end
    endtask

    task automatic test_random(input bit s16, input int n);
        logic [15:0] d;
        logic [15:0] exp_dout;
        bit          exp_tdo;
        select_width(s16);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(7) == 0) byp = ~byp;
            ext = 1'($urandom_range(1));
            d   = 16'($urandom) & mask_w();
            cycle($urandom_range(4) == 0, $urandom_range(3) != 0, $urandom_range(5) == 0,
                  1'($urandom_range(1)), d);
            exp_dout = ext ? m_ur : d;
            exp_tdo  = byp ? m_bp : mq[0];
            checks++; if (obs_tdo !== exp_tdo) begin failures++; $display("[TB] FAIL rnd_tdo w=%0d k=%0d got=%0b exp=%0b", W, k, obs_tdo, exp_tdo); end
            checks++; if (obs_dout !== exp_dout) begin failures++; $display("[TB] FAIL rnd_dout w=%0d k=%0d got=%h exp=%h", W, k, obs_dout, exp_dout); end
            checks++; if (obs_count !== m_count) begin failures++; $display("[TB] FAIL rnd_count w=%0d k=%0d got=%0d exp=%0d", W, k, obs_count, m_count); end
            checks++; if (obs_full !== (m_count == W)) begin failures++; $display("[TB] FAIL rnd_full w=%0d k=%0d got=%0b exp=%0b", W, k, obs_full, m_count == W); end
            checks++; if (obs_short !== m_short) begin failures++; $display("[TB] FAIL rnd_short w=%0d k=%0d got=%0b exp=%0b", W, k, obs_short, m_short); end
            checks++; if (obs_state !== m_state) begin failures++; $display("[TB] FAIL rnd_state w=%0d k=%0d got=%0d exp=%0d", W, k, obs_state, m_state); end
        end
        byp = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_reset();
        #12;
        test_reset();
        test_capture_shift_update(1'b0, 16'h00A5, 16'h003C);
        test_capture_shift_update(1'b1, 16'hA5C3, 16'h3C96);
        test_short_update(1'b0);
        test_short_update(1'b1);
        test_bypass();
        test_back_to_back();
        test_extest_passthrough();
        test_random(1'b0, 300);
        test_random(1'b1, 300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
